// File: rtl/clock_div_controller_pkg.sv
// Shared types and defaults for the run/stop clock divider controller.
package clkdiv_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_t;

  localparam int CLKDIV_W       = 12;
  localparam int CLKDIV_DEFAULT = 4095;

endpackage

// File: rtl/clock_div_controller_if.sv
// Divisor configuration handshake: requester offers cfg_div, controller accepts or flags zero.
interface clock_div_controller_if #(
  parameter int W = 12
) ();

  logic         cfg_valid;
  logic         cfg_ready;
  logic [W-1:0] cfg_div;
  logic         cfg_err;

  modport master (
    output cfg_valid,
    output cfg_div,
    input  cfg_ready,
    input  cfg_err
  );

  modport slave (
    input  cfg_valid,
    input  cfg_div,
    output cfg_ready,
    output cfg_err
  );

endinterface

// File: rtl/clock_div_controller_counter.sv
// Half-period counter: wraps at div-1, toggles clock_out and pulses tick on the same edge.
module clkdiv_counter #(
  parameter int W = 12
) (
  input  logic         clock_in,
  input  logic         reset_n,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] div,
  output logic         tc,
  output logic         clock_out,
  output logic         tick
);

  logic [W-1:0] cnt;

  // >= rather than == so a smaller divisor can never strand the count above div-1
  assign tc = en & ~clr & (cnt >= (div - W'(1)));

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      cnt       <= '0;
      clock_out <= 1'b0;
      tick      <= 1'b0;
    end else if (clr) begin
      cnt       <= '0;
      clock_out <= 1'b0;
      tick      <= 1'b0;
    end else if (tc) begin
      cnt       <= '0;
      clock_out <= ~clock_out;
      tick      <= 1'b1;
    end else if (en) begin
      cnt  <= cnt + W'(1);
      tick <= 1'b0;
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/clock_div_controller.sv
// Run/stop and reconfiguration controller around the half-period divider.
// state    | meaning
// IDLE     | counter held at 0, clock_out parked low, divisor writes apply directly
// RUN      | dividing; divisor writes are held pending until the next terminal count
// STOPPING | stop seen while high; finishing the high phase before parking low
module clock_div_controller
  import clkdiv_pkg::*;
#(
  parameter int W           = CLKDIV_W,
  parameter int DIV_DEFAULT = CLKDIV_DEFAULT
) (
  input  logic                    clock_in,
  input  logic                    reset_n,
  clock_div_controller_if.slave   cfg,
  input  logic                    start,
  input  logic                    stop,
  output logic                    clock_out,
  output logic                    tick,
  output logic                    busy
);

  state_t       state;
  logic [W-1:0] active_div;
  logic [W-1:0] pending_div;
  logic         pending_vld;
  logic         cnt_en;
  logic         cnt_clr;
  logic         tc;
  logic         xfer;
  logic         xfer_zero;
  logic         to_idle;

  assign xfer      = cfg.cfg_valid & cfg.cfg_ready;
  assign xfer_zero = xfer & (cfg.cfg_div == '0);

  assign cnt_en  = (state != IDLE);
  assign cnt_clr = (state == IDLE) | ((state == RUN) & stop & ~clock_out);

  // A stop in RUN whose high phase ends on this very edge goes straight to IDLE
  assign to_idle = ((state == RUN) & stop & (~clock_out | tc)) |
                   ((state == STOPPING) & tc);

  clkdiv_counter #(.W(W)) u_counter (
    .clock_in  (clock_in),
    .reset_n   (reset_n),
    .en        (cnt_en),
    .clr       (cnt_clr),
    .div       (active_div),
    .tc        (tc),
    .clock_out (clock_out),
    .tick      (tick)
  );

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      busy          <= 1'b0;
      active_div    <= W'(DIV_DEFAULT);
      pending_div   <= '0;
      pending_vld   <= 1'b0;
      cfg.cfg_ready <= 1'b1;
      cfg.cfg_err   <= 1'b0;
    end else begin
      cfg.cfg_err <= xfer_zero;

      case (state)
        IDLE: begin
          if (start && !stop) begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (to_idle) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (stop) begin
            state <= STOPPING;
          end
        end
        STOPPING: begin
          if (to_idle) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase

      // Pending and a new transfer are exclusive: cfg_ready is low while pending_vld
      if (pending_vld && ((state == IDLE) || tc || to_idle)) begin
        active_div    <= pending_div;
        pending_vld   <= 1'b0;
        cfg.cfg_ready <= 1'b1;
      end else if (xfer && !xfer_zero) begin
        if (state == IDLE) begin
          active_div <= cfg.cfg_div;
        end else begin
          pending_div   <= cfg.cfg_div;
          pending_vld   <= 1'b1;
          cfg.cfg_ready <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_clock_div_controller.sv
// Scoreboard bench: expected tick edges are queued as stimulus is driven, popped by a tick monitor.
module tb_clock_div_controller;

  localparam int W = 12;

  typedef struct {
    int   cyc;
    logic lvl;
  } exp_t;

  logic clock_in;
  logic reset_n;
  logic start;
  logic stop;
  logic clock_out;
  logic tick;
  logic busy;

  int   cyc;
  int   n_cmp;
  int   n_err;
  exp_t exp_q[$];

  clock_div_controller_if #(.W(W)) cfg_if ();

  clock_div_controller #(.W(W), .DIV_DEFAULT(4)) dut (
    .clock_in  (clock_in),
    .reset_n   (reset_n),
    .cfg       (cfg_if),
    .start     (start),
    .stop      (stop),
    .clock_out (clock_out),
    .tick      (tick),
    .busy      (busy)
  );

  initial clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  always @(posedge clock_in) cyc <= cyc + 1;

  // Every observed tick must match the oldest queued expectation in cycle and level
  always @(negedge clock_in) begin
    if (reset_n && tick) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL tick_unexpected cyc=%0d clock_out=%b required=no tick", cyc, clock_out);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (cyc !== e.cyc || clock_out !== e.lvl) begin
          n_err++;
          $display("FAIL tick_edge got cyc=%0d lvl=%b required cyc=%0d lvl=%b",
                   cyc, clock_out, e.cyc, e.lvl);
        end
      end
    end
  end

  task automatic push_ticks(input int first, input int step, input int n, input logic lvl0);
    logic l;
    l = lvl0;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{first + i * step, l});
      l = ~l;
    end
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) @(negedge clock_in);
  endtask

  task automatic start_run(output int s);
    start = 1'b1;
    @(negedge clock_in);
    start = 1'b0;
    s = cyc;
  endtask

  task automatic offer(input logic [W-1:0] d);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_div   = d;
    @(negedge clock_in);
    cfg_if.cfg_valid = 1'b0;
  endtask

  task automatic do_reset();
    #2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL ticks_missing got %0d left required 0 (next cyc=%0d)", exp_q.size(), exp_q[0].cyc);
    end
    exp_q.delete();
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({clock_out, tick, busy, cfg_if.cfg_ready, cfg_if.cfg_err} !== 5'b00010) begin
      n_err++;
      $display("FAIL reset_outputs got out/tick/busy/rdy/err=%b%b%b%b%b required 00010",
               clock_out, tick, busy, cfg_if.cfg_ready, cfg_if.cfg_err);
    end
    @(negedge clock_in);
    reset_n = 1'b1;
    @(negedge clock_in);
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({clock_out, busy, cfg_if.cfg_ready} !== 3'b001) begin
      n_err++;
      $display("FAIL reset_release got out/busy/rdy=%b%b%b required 001", clock_out, busy, cfg_if.cfg_ready);
    end
  endtask

  task automatic test_basic_run();
    int s;
    start_run(s);
    push_ticks(s + 4, 4, 4, 1'b1);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL busy_run got %b required 1", busy);
    end
    wait_to(s + 17);
    do_reset();
  endtask

  task automatic test_reconfig_mid();
    int s;
    start_run(s);
    push_ticks(s + 4, 4, 2, 1'b1);
    push_ticks(s + 10, 2, 4, 1'b1);
    wait_to(s + 5);
    offer(12'd2);
    n_cmp++;
    if (cfg_if.cfg_ready !== 1'b0) begin
      n_err++;
      $display("FAIL ready_pending got %b required 0", cfg_if.cfg_ready);
    end
    wait_to(s + 7);
    n_cmp++;
    if (cfg_if.cfg_ready !== 1'b0) begin
      n_err++;
      $display("FAIL ready_before_tc got %b required 0", cfg_if.cfg_ready);
    end
    wait_to(s + 8);
    n_cmp++;
    if (cfg_if.cfg_ready !== 1'b1) begin
      n_err++;
      $display("FAIL ready_after_apply got %b required 1", cfg_if.cfg_ready);
    end
    wait_to(s + 17);
    do_reset();
  endtask

  task automatic test_reconfig_on_tc();
    int s;
    start_run(s);
    push_ticks(s + 4, 4, 2, 1'b1);
    push_ticks(s + 10, 2, 2, 1'b1);
    wait_to(s + 3);
    offer(12'd2);
    wait_to(s + 13);
    do_reset();
  endtask

  task automatic test_zero_div();
    int s;
    offer(12'd0);
    n_cmp++;
    if ({cfg_if.cfg_err, cfg_if.cfg_ready} !== 2'b11) begin
      n_err++;
      $display("FAIL zero_idle got err/rdy=%b%b required 11", cfg_if.cfg_err, cfg_if.cfg_ready);
    end
    @(negedge clock_in);
    n_cmp++;
    if (cfg_if.cfg_err !== 1'b0) begin
      n_err++;
      $display("FAIL zero_idle_pulse got %b required 0", cfg_if.cfg_err);
    end
    start_run(s);
    push_ticks(s + 4, 4, 3, 1'b1);
    wait_to(s + 5);
    offer(12'd0);
    n_cmp++;
    if ({cfg_if.cfg_err, cfg_if.cfg_ready} !== 2'b11) begin
      n_err++;
      $display("FAIL zero_run got err/rdy=%b%b required 11", cfg_if.cfg_err, cfg_if.cfg_ready);
    end
    @(negedge clock_in);
    n_cmp++;
    if (cfg_if.cfg_err !== 1'b0) begin
      n_err++;
      $display("FAIL zero_run_pulse got %b required 0", cfg_if.cfg_err);
    end
    wait_to(s + 13);
    do_reset();
  endtask

  task automatic test_stop();
    int s;
    start_run(s);
    push_ticks(s + 4, 4, 2, 1'b1);
    wait_to(s + 5);
    stop = 1'b1;
    @(negedge clock_in);
    stop = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL stopping_busy got %b required 1", busy);
    end
    wait_to(s + 8);
    n_cmp++;
    if ({busy, clock_out} !== 2'b00) begin
      n_err++;
      $display("FAIL stop_high_park got busy/out=%b%b required 00", busy, clock_out);
    end
    wait_to(s + 14);
    start_run(s);
    push_ticks(s + 4, 4, 2, 1'b1);
    wait_to(s + 9);
    stop = 1'b1;
    @(negedge clock_in);
    stop = 1'b0;
    n_cmp++;
    if ({busy, clock_out} !== 2'b00) begin
      n_err++;
      $display("FAIL stop_low_park got busy/out=%b%b required 00", busy, clock_out);
    end
    wait_to(s + 16);
    do_reset();
  endtask

  task automatic test_start_stop_and_div1();
    int s;
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clock_in);
    start = 1'b0;
    stop  = 1'b0;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL start_stop_idle got busy=%b required 0", busy);
    end
    repeat (6) @(negedge clock_in);
    offer(12'd1);
    start_run(s);
    push_ticks(s + 1, 1, 8, 1'b1);
    wait_to(s + 5);
    n_cmp++;
    if (tick !== 1'b1) begin
      n_err++;
      $display("FAIL div1_tick_high got %b required 1", tick);
    end
    wait_to(s + 8);
    do_reset();
  endtask

  task automatic test_reset_mid_run();
    int s;
    start_run(s);
    push_ticks(s + 4, 4, 1, 1'b1);
    wait_to(s + 5);
    offer(12'd2);
    n_cmp++;
    if (cfg_if.cfg_ready !== 1'b0) begin
      n_err++;
      $display("FAIL pending_before_reset got rdy=%b required 0", cfg_if.cfg_ready);
    end
    do_reset();
    start_run(s);
    push_ticks(s + 4, 4, 3, 1'b1);
    wait_to(s + 13);
    do_reset();
  endtask

  initial begin
    cyc              = 0;
    n_cmp            = 0;
    n_err            = 0;
    reset_n          = 1'b0;
    start            = 1'b0;
    stop             = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_div   = '0;
    repeat (3) @(negedge clock_in);
    reset_n = 1'b1;
    @(negedge clock_in);

    test_reset();
    test_basic_run();
    test_reconfig_mid();
    test_reconfig_on_tc();
    test_zero_div();
    test_stop();
    test_start_stop_and_div1();
    test_reset_mid_run();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
